// File: rtl/trace_chk_pkg.sv
// Shared definitions for the retire trace checker: golden entry layout,
// fail_field bit positions, FSM encoding and the buffered retire event.
package trace_chk_pkg;

    // Golden entry bit fields (128-bit entry)
    localparam int PC_HI    = 127;
    localparam int PC_LO    = 96;
    localparam int INST_HI  = 95;
    localparam int INST_LO  = 64;
    localparam int WE_BIT   = 63;
    localparam int WADDR_HI = 62;
    localparam int WADDR_LO = 58;
    localparam int END_BIT  = 57;
    localparam int WDATA_HI = 31;
    localparam int WDATA_LO = 0;

    // fail_field bit positions
    localparam int FAIL_PC_BIT   = 0;
    localparam int FAIL_INST_BIT = 1;
    localparam int FAIL_RF_BIT   = 2;

    // Packed retire event width: pc + inst + we + waddr + wdata
    localparam int EVT_W = 102;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } retire_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_HALT    = 3'd3,
        ST_DONE    = 3'd4
    } chk_state_t;

    // A write to $0 never changes architectural state, so it counts as no write.
    function automatic logic norm_we(input logic we, input logic [4:0] waddr);
        return we && (waddr != 5'd0);
    endfunction

endpackage

// File: rtl/retire_event_fifo.sv
// Synchronous FIFO buffering retire events between the CPU and the checker.
// Pushes into a full FIFO and pops from an empty FIFO are ignored; fullness
// is the registered count, so a same-cycle pop never makes room for a push.
module retire_event_fifo
    import trace_chk_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [EVT_W-1:0] din,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/retire_trace_checker.sv
// Compares the CPU retire stream against a golden trace fetched over a
// req/ack port. Retire events are buffered in a FIFO; each golden entry is
// fetched, then compared with the FIFO head in a single COMPARE cycle.
module retire_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GOLD_AW    = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               retire_valid,
    input  logic [31:0]        retire_pc,
    input  logic [31:0]        retire_inst,
    input  logic               retire_we,
    input  logic [4:0]         retire_waddr,
    input  logic [31:0]        retire_wdata,
    output logic               gold_req,
    output logic [GOLD_AW-1:0] gold_addr,
    input  logic               gold_ack,
    input  logic [127:0]       gold_data,
    output logic               done,
    output logic               mismatch,
    output logic               overflow,
    output logic [31:0]        match_count,
    output logic [GOLD_AW-1:0] fail_index,
    output logic [2:0]         fail_field,
    output logic [31:0]        fail_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    chk_state_t         state_q, state_d;
    retire_evt_t        gold_evt_q, gold_evt_d;
    logic               gold_end_q, gold_end_d;
    logic [GOLD_AW-1:0] gold_addr_q, gold_addr_d;
    logic               done_q, done_d;
    logic               mismatch_q, mismatch_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        match_count_q, match_count_d;
    logic [GOLD_AW-1:0] fail_index_q, fail_index_d;
    logic [2:0]         fail_field_q, fail_field_d;
    logic [31:0]        fail_pc_q, fail_pc_d;

    retire_evt_t        push_evt, head_evt;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push_req, ovf_hit;
    logic [2:0]         diff;
    logic               gold_rsvd_unused;

    // Reserved golden bits carry no meaning for the compare
    assign gold_rsvd_unused = ^gold_data[END_BIT-1:WDATA_HI+1];

    assign push_evt = {retire_pc, retire_inst, norm_we(retire_we, retire_waddr),
                       retire_waddr, retire_wdata};

    retire_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_evt),
        .dout  (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Field-by-field difference between FIFO head and captured golden entry
    always_comb begin
        diff                = '0;
        diff[FAIL_PC_BIT]   = (head_evt.pc != gold_evt_q.pc);
        diff[FAIL_INST_BIT] = (head_evt.inst != gold_evt_q.inst);
        diff[FAIL_RF_BIT]   = (head_evt.we != gold_evt_q.we) ||
                              (head_evt.we && ((head_evt.waddr != gold_evt_q.waddr) ||
                                               (head_evt.wdata != gold_evt_q.wdata)));
    end

    // FSM next state, FIFO control and result register updates
    always_comb begin
        state_d       = state_q;
        gold_evt_d    = gold_evt_q;
        gold_end_d    = gold_end_q;
        gold_addr_d   = gold_addr_q;
        done_d        = done_q;
        mismatch_d    = mismatch_q;
        overflow_d    = overflow_q;
        match_count_d = match_count_q;
        fail_index_d  = fail_index_q;
        fail_field_d  = fail_field_q;
        fail_pc_d     = fail_pc_q;
        fifo_pop      = 1'b0;

        // Retire events are accepted until the checker reaches a terminal state
        push_req  = retire_valid && (state_q != ST_HALT) && (state_q != ST_DONE);
        ovf_hit   = push_req && fifo_full;
        fifo_push = push_req && !fifo_full;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (gold_ack) begin
                    gold_evt_d = '{pc:    gold_data[PC_HI:PC_LO],
                                   inst:  gold_data[INST_HI:INST_LO],
                                   we:    norm_we(gold_data[WE_BIT], gold_data[WADDR_HI:WADDR_LO]),
                                   waddr: gold_data[WADDR_HI:WADDR_LO],
                                   wdata: gold_data[WDATA_HI:WDATA_LO]};
                    gold_end_d = gold_data[END_BIT];
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (gold_end_q) begin
                    done_d  = !ovf_hit;
                    state_d = ST_DONE;
                end else if (diff == 3'b000) begin
                    fifo_pop      = 1'b1;
                    match_count_d = (match_count_q == 32'hFFFF_FFFF) ? match_count_q
                                                                     : match_count_q + 32'd1;
                    gold_addr_d   = gold_addr_q + GOLD_AW'(1);
                    state_d       = ((fifo_count > CNT_W'(1)) || fifo_push) ? ST_FETCH : ST_IDLE;
                end else begin
                    if (!mismatch_q) begin
                        fail_field_d = diff;
                        fail_index_d = gold_addr_q;
                        fail_pc_d    = head_evt.pc;
                    end
                    mismatch_d = 1'b1;
                    state_d    = ST_HALT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (ovf_hit) begin
            overflow_d = 1'b1;
            state_d    = ST_HALT;
        end
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            gold_evt_q    <= '0;
            gold_end_q    <= 1'b0;
            gold_addr_q   <= '0;
            done_q        <= 1'b0;
            mismatch_q    <= 1'b0;
            overflow_q    <= 1'b0;
            match_count_q <= '0;
            fail_index_q  <= '0;
            fail_field_q  <= '0;
            fail_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            gold_evt_q    <= gold_evt_d;
            gold_end_q    <= gold_end_d;
            gold_addr_q   <= gold_addr_d;
            done_q        <= done_d;
            mismatch_q    <= mismatch_d;
            overflow_q    <= overflow_d;
            match_count_q <= match_count_d;
            fail_index_q  <= fail_index_d;
            fail_field_q  <= fail_field_d;
            fail_pc_q     <= fail_pc_d;
        end
    end

    assign gold_req    = (state_q == ST_FETCH);
    assign gold_addr   = gold_addr_q;
    assign done        = done_q;
    assign mismatch    = mismatch_q;
    assign overflow    = overflow_q;
    assign match_count = match_count_q;
    assign fail_index  = fail_index_q;
    assign fail_field  = fail_field_q;
    assign fail_pc     = fail_pc_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Bench for retire_trace_checker: table of retire/golden vector pairs,
// a golden-memory responder with programmable ack delay, and a scoreboard
// of expected compare verdicts consumed as the DUT reports results.
module tb_retire_trace_checker;

    localparam int DEPTH = 4;
    localparam int AW    = 13;

    logic          clk, reset;
    logic          retire_valid, retire_we;
    logic [31:0]   retire_pc, retire_inst, retire_wdata;
    logic [4:0]    retire_waddr;
    logic          gold_req;
    logic [AW-1:0] gold_addr;
    wire           gold_ack;
    logic [127:0]  gold_data;
    logic          done, mismatch, overflow;
    logic [31:0]   match_count;
    logic [AW-1:0] fail_index;
    logic [2:0]    fail_field;
    logic [31:0]   fail_pc;

    logic          resp_en, ack_auto, ack_man;
    int            ack_dly;
    logic [127:0]  gold_mem [16];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;   logic [31:0] inst; logic we;  logic [4:0] wa;  logic [31:0] wd;
        logic [31:0] gpc;  logic [31:0] ginst; logic gwe; logic [4:0] gwa; logic [31:0] gwd;
        logic [2:0]  efield;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          idx;
        logic [2:0]  field;
    } sb_t;

    vec_t tbl [10];
    sb_t  sb [$];

    assign gold_ack = resp_en ? ack_auto : ack_man;

    retire_trace_checker #(.FIFO_DEPTH(DEPTH), .GOLD_AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_inst  (retire_inst),
        .retire_we    (retire_we),
        .retire_waddr (retire_waddr),
        .retire_wdata (retire_wdata),
        .gold_req     (gold_req),
        .gold_addr    (gold_addr),
        .gold_ack     (gold_ack),
        .gold_data    (gold_data),
        .done         (done),
        .mismatch     (mismatch),
        .overflow     (overflow),
        .match_count  (match_count),
        .fail_index   (fail_index),
        .fail_field   (fail_field),
        .fail_pc      (fail_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [127:0] mk_gold(input vec_t v);
        return {v.gpc, v.ginst, v.gwe, v.gwa, 1'b0, 25'h1555555, v.gwd};
    endfunction

    // Golden memory responder: ack after ack_dly request cycles
    initial begin
        int cnt;
        cnt       = 0;
        ack_auto  = 1'b0;
        gold_data = '0;
        forever begin
            @(negedge clk);
            gold_data = gold_mem[gold_addr[3:0]];
            if (gold_req && !ack_auto) begin
                if (cnt >= ack_dly) begin
                    ack_auto = 1'b1;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                ack_auto = 1'b0;
                cnt      = 0;
            end
        end
    end

    // Scoreboard monitor: each compare result the DUT reports consumes one expectation
    initial begin
        logic [31:0] prev_mc;
        logic        prev_mm;
        sb_t         it;
        prev_mc = '0;
        prev_mm = 1'b0;
        forever begin
            @(negedge clk);
            if (match_count > prev_mc) begin
                check("sb_count_step", match_count - prev_mc, 1);
                if (sb.size() == 0) begin
                    check("sb_unexpected_match", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("sb_match_verdict", 3'b000, it.field);
                end
            end
            if (mismatch && !prev_mm) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_mismatch", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("sb_fail_field", fail_field, it.field);
                    check("sb_fail_pc", fail_pc, it.pc);
                    check("sb_fail_index", fail_index, it.idx);
                end
            end
            prev_mc = match_count;
            prev_mm = mismatch;
        end
    end

    task automatic do_reset();
        retire_valid = 1'b0;
        reset        = 1'b0;
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        sb.delete();
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_inst  = inst;
        retire_we    = we;
        retire_waddr = wa;
        retire_wdata = wd;
        @(negedge clk);
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (!(done || mismatch || overflow) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("wait_end_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Load n golden entries plus an end marker, retire them and one trailing event
    task automatic run_seq(input int first, input int n);
        logic [127:0] endw;
        for (int i = 0; i < n; i++) gold_mem[i] = mk_gold(tbl[first+i]);
        endw          = '0;
        endw[127:96]  = 32'hFFFF_FFF0;
        endw[57]      = 1'b1;
        gold_mem[n]   = endw;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: tbl[first+i].pc, idx: i, field: tbl[first+i].efield});
            drive(tbl[first+i].pc, tbl[first+i].inst, tbl[first+i].we, tbl[first+i].wa, tbl[first+i].wd);
        end
        drive(tbl[first+n-1].pc + 32'd4, 32'h0, 1'b0, 5'd0, 32'h0);
        retire_valid = 1'b0;
        wait_end();
    endtask

    initial begin
        logic any_req;
        int   k;

        tbl[0] = '{32'h00400000, 32'h20080001, 1'b1, 5'd8,  32'd1,    32'h00400000, 32'h20080001, 1'b1, 5'd8,  32'd1,      3'b000};
        tbl[1] = '{32'h00400004, 32'h20090002, 1'b1, 5'd9,  32'd2,    32'h00400004, 32'h20090002, 1'b1, 5'd9,  32'd2,      3'b000};
        tbl[2] = '{32'h00400008, 32'h200a0003, 1'b1, 5'd10, 32'd3,    32'h00400008, 32'h200a0003, 1'b1, 5'd10, 32'd3,      3'b000};
        tbl[3] = tbl[0];
        tbl[4] = '{32'h00400004, 32'h20090002, 1'b1, 5'd9,  32'd5,    32'h00400004, 32'h20090002, 1'b1, 5'd9,  32'd2,      3'b100};
        tbl[5] = '{32'h00400000, 32'h2000dead, 1'b1, 5'd0,  32'hdead, 32'h00400000, 32'h2000dead, 1'b0, 5'd0,  32'd0,      3'b000};
        tbl[6] = '{32'h00400004, 32'h00000000, 1'b0, 5'd0,  32'd0,    32'h00400004, 32'h00000000, 1'b1, 5'd0,  32'h1234,   3'b000};
        tbl[7] = '{32'h00400008, 32'h20080007, 1'b1, 5'd8,  32'd7,    32'h00400008, 32'h20080007, 1'b1, 5'd8,  32'd7,      3'b000};
        tbl[8] = '{32'h0040000c, 32'h20090008, 1'b1, 5'd9,  32'd8,    32'h0040000c, 32'h20090008, 1'b1, 5'd9,  32'd8,      3'b000};
        tbl[9] = '{32'h00400000, 32'h20080001, 1'b1, 5'd8,  32'd1,    32'h00400010, 32'h20080002, 1'b1, 5'd8,  32'd1,      3'b011};

        for (int i = 0; i < 16; i++) gold_mem[i] = '0;
        resp_en = 1'b1; ack_man = 1'b0; ack_dly = 1;
        retire_pc = '0; retire_inst = '0; retire_we = 1'b0; retire_waddr = '0; retire_wdata = '0;
        do_reset();

        // Reset state
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_overflow", overflow, 0);
        check("rst_match_count", match_count, 0);
        check("rst_fail_index", fail_index, 0);
        check("rst_fail_field", fail_field, 0);
        check("rst_fail_pc", fail_pc, 0);
        check("rst_gold_req", gold_req, 0);
        check("rst_gold_addr", gold_addr, 0);

        // Matching three-entry trace, ack one cycle after request
        ack_dly = 1;
        run_seq(0, 3);
        check("t1_match_count", match_count, 3);
        check("t1_done", done, 1);
        check("t1_mismatch", mismatch, 0);
        check("t1_gold_addr", gold_addr, 3);
        check("t1_sb_empty", sb.size(), 0);

        // Wrong write data on entry 1
        do_reset();
        run_seq(3, 2);
        check("t2_mismatch", mismatch, 1);
        check("t2_fail_field", fail_field, 3'b100);
        check("t2_fail_index", fail_index, 1);
        check("t2_fail_pc", fail_pc, 32'h00400004);
        check("t2_match_count", match_count, 1);
        check("t2_done", done, 0);
        any_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_req = any_req | gold_req;
        end
        check("t2_req_quiet", any_req, 0);
        check("t2_sb_empty", sb.size(), 0);

        // Writes to $0 normalise to no write on both sides
        do_reset();
        run_seq(5, 2);
        check("t3_match_count", match_count, 2);
        check("t3_done", done, 1);
        check("t3_mismatch", mismatch, 0);
        check("t3_gold_addr", gold_addr, 2);

        // pc and inst mismatch on the very first entry
        do_reset();
        ack_dly = 0;
        run_seq(9, 1);
        check("t7_fail_field", fail_field, 3'b011);
        check("t7_fail_pc", fail_pc, 32'h00400000);
        check("t7_match_count", match_count, 0);

        // Overflow: retire every cycle while the golden ack is slow
        do_reset();
        ack_dly = 5;
        for (int i = 0; i < 16; i++) gold_mem[i] = mk_gold(tbl[0]);
        for (int i = 0; i < 8; i++) begin
            drive(32'h00000100 + 32'(i * 4), 32'h0, 1'b0, 5'd0, 32'h0);
            #1;
            check($sformatf("t4_ovf_step%0d", i), overflow, (i >= 4) ? 1 : 0);
        end
        retire_valid = 1'b0;
        any_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_req = any_req | gold_req;
        end
        check("t4_halt_req", any_req, 0);
        check("t4_mismatch", mismatch, 0);
        check("t4_done", done, 0);
        check("t4_match_count", match_count, 0);

        // Push and pop in the same COMPARE cycle with one entry buffered
        do_reset();
        ack_dly = 0;
        gold_mem[0] = mk_gold(tbl[7]);
        gold_mem[1] = mk_gold(tbl[8]);
        gold_mem[2] = 128'h0;
        gold_mem[2][57] = 1'b1;
        sb.push_back('{pc: tbl[7].pc, idx: 0, field: 3'b000});
        drive(tbl[7].pc, tbl[7].inst, tbl[7].we, tbl[7].wa, tbl[7].wd);
        retire_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            #1;
            if (gold_ack) break;
            k++;
        end
        check("t5_ack_seen", (k < 20) ? 1 : 0, 1);
        @(negedge clk);
        sb.push_back('{pc: tbl[8].pc, idx: 1, field: 3'b000});
        drive(tbl[8].pc, tbl[8].inst, tbl[8].we, tbl[8].wa, tbl[8].wd);
        retire_valid = 1'b0;
        #1;
        check("t5_refetch", gold_req, 1);
        check("t5_mid_count", match_count, 1);
        drive(32'h00400010, 32'h0, 1'b0, 5'd0, 32'h0);
        retire_valid = 1'b0;
        wait_end();
        check("t5_match_count", match_count, 2);
        check("t5_done", done, 1);
        check("t5_gold_addr", gold_addr, 2);
        check("t5_sb_empty", sb.size(), 0);

        // Reset during FETCH, then a late ack
        do_reset();
        resp_en = 1'b0;
        gold_mem[0] = mk_gold(tbl[0]);
        drive(tbl[0].pc, tbl[0].inst, tbl[0].we, tbl[0].wa, tbl[0].wd);
        retire_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            #1;
            if (gold_req) break;
            k++;
        end
        check("t6_req_seen", (k < 20) ? 1 : 0, 1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset   = 1'b1;
        ack_man = 1'b1;
        check("t6_req_drop", gold_req, 0);
        check("t6_gold_addr", gold_addr, 0);
        check("t6_match_count", match_count, 0);
        check("t6_done", done, 0);
        check("t6_mismatch", mismatch, 0);
        repeat (4) @(negedge clk);
        check("t6_ack_ignored", match_count, 0);
        check("t6_idle_req", gold_req, 0);
        check("t6_addr_hold", gold_addr, 0);
        check("t6_overflow", overflow, 0);
        ack_man = 1'b0;
        resp_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
